// File: rtl/pattern_player.sv
// Stored-pattern test player: applies each stored stimulus vector, waits SETTLE cycles,
// then compares the DUT response against the masked expectation and tallies failures.
module pattern_player #(
   parameter int NINPUTS  = 5,
   parameter int NOUTPUTS = 2,
   parameter int DEPTH    = 16,
   parameter int SETTLE   = 4,
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [NINPUTS-1:0]  load_pi,
   input  logic [NOUTPUTS-1:0] load_xpct,
   input  logic [NOUTPUTS-1:0] load_mask,
   input  logic                start,
   output logic [NINPUTS-1:0]  pi,
   input  logic [NOUTPUTS-1:0] po,
   output logic                busy,
   output logic                done,
   output logic                pat_fail,
   output logic [IW-1:0]       pat_idx,
   output logic [CW-1:0]       fail_count,
   output logic                first_fail_valid,
   output logic [IW-1:0]       first_fail_idx,
   output logic [CW-1:0]       pat_count
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_MEASURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
   localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE - 1);

   state_t               state_q, state_d;
   logic [NINPUTS-1:0]   pi_q, pi_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [SW-1:0]        cnt_q, cnt_d;
   logic [CW-1:0]        pat_count_q, pat_count_d;
   logic [CW-1:0]        fail_count_q, fail_count_d;
   logic                 ffv_q, ffv_d;
   logic [IW-1:0]        ffi_q, ffi_d;
   logic                 pat_fail_q, pat_fail_d;
   logic                 idle_like;
   logic                 wr_en;
   logic                 miss;

   logic [NINPUTS-1:0]   mem_pi_q   [DEPTH];
   logic [NOUTPUTS-1:0]  mem_xpct_q [DEPTH];
   logic [NOUTPUTS-1:0]  mem_mask_q [DEPTH];

   always_comb begin
      state_d      = state_q;
      pi_d         = pi_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      pat_count_d  = pat_count_q;
      fail_count_d = fail_count_q;
      ffv_d        = ffv_q;
      ffi_d        = ffi_q;
      pat_fail_d   = 1'b0;
      idle_like    = (state_q == S_IDLE) || (state_q == S_DONE);
      // rst gating keeps load_ready low while reset is held
      load_ready   = idle_like && (pat_count_q < DEPTH_C) && !start && !clr && !rst;
      wr_en        = load_valid && load_ready;
      miss         = |((po ^ mem_xpct_q[idx_q]) & mem_mask_q[idx_q]);

      if (wr_en) pat_count_d = pat_count_q + CW'(1);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (clr) begin
               state_d      = S_IDLE;
               pat_count_d  = '0;
               pi_d         = '0;
               idx_d        = '0;
               fail_count_d = '0;
               ffv_d        = 1'b0;
               ffi_d        = '0;
            end else if (start) begin
               fail_count_d = '0;
               ffv_d        = 1'b0;
               ffi_d        = '0;
               if (pat_count_q != '0) begin
                  state_d = S_SETTLE;
                  idx_d   = '0;
                  cnt_d   = '0;
                  pi_d    = mem_pi_q[0];
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) state_d = S_MEASURE;
            else                      cnt_d   = cnt_q + SW'(1);
         end
         S_MEASURE: begin
            if (miss) begin
               pat_fail_d   = 1'b1;
               fail_count_d = fail_count_q + CW'(1);
               if (!ffv_q) begin
                  ffv_d = 1'b1;
                  ffi_d = idx_q;
               end
            end
            if (CW'(idx_q) == pat_count_q - CW'(1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_SETTLE;
               idx_d   = idx_q + IW'(1);
               cnt_d   = '0;
               pi_d    = mem_pi_q[idx_q + IW'(1)];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pi_q         <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         pat_count_q  <= '0;
         fail_count_q <= '0;
         ffv_q        <= 1'b0;
         ffi_q        <= '0;
         pat_fail_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pi_q         <= pi_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         pat_count_q  <= pat_count_d;
         fail_count_q <= fail_count_d;
         ffv_q        <= ffv_d;
         ffi_q        <= ffi_d;
         pat_fail_q   <= pat_fail_d;
      end
   end

   // Pattern store needs no reset: entries beyond pat_count are never read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_pi_q[pat_count_q[IW-1:0]]   <= load_pi;
         mem_xpct_q[pat_count_q[IW-1:0]] <= load_xpct;
         mem_mask_q[pat_count_q[IW-1:0]] <= load_mask;
      end
   end

   assign pi               = pi_q;
   assign busy             = (state_q == S_SETTLE) || (state_q == S_MEASURE);
   assign done             = (state_q == S_DONE);
   assign pat_fail         = pat_fail_q;
   assign pat_idx          = idx_q;
   assign fail_count       = fail_count_q;
   assign first_fail_valid = ffv_q;
   assign first_fail_idx   = ffi_q;
   assign pat_count        = pat_count_q;

endmodule

// File: tb/tb_pattern_player.sv
// Bench for pattern_player: a small DUT model drives po, a scoreboard queue holds the
// expected stimulus and pass/fail per pattern, popped at each pattern boundary.
module tb_pattern_player;
   localparam int NI    = 5;
   localparam int NO    = 2;
   localparam int DEPTH = 16;
   localparam int SET   = 4;

   logic          clk = 1'b0;
   logic          rst, clr, load_valid, start;
   logic [NI-1:0] load_pi, pi;
   logic [NO-1:0] load_xpct, load_mask, po;
   logic          load_ready, busy, done, pat_fail, first_fail_valid;
   logic [3:0]    pat_idx, first_fail_idx;
   logic [4:0]    fail_count, pat_count;

   int n_checks = 0;
   int n_pass   = 0;

   logic [NI-1:0] st_pi[$];
   logic [NO-1:0] st_x[$];
   logic [NO-1:0] st_m[$];
   logic [NI-1:0] exp_pi_q[$];
   logic          exp_fail_q[$];
   logic          inj_en = 1'b0;
   logic [3:0]    inj_idx = '0;

   always #5 clk = ~clk;

   pattern_player #(.NINPUTS(NI), .NOUTPUTS(NO), .DEPTH(DEPTH), .SETTLE(SET)) dut (
      .clk(clk), .rst(rst), .clr(clr), .load_valid(load_valid), .load_ready(load_ready),
      .load_pi(load_pi), .load_xpct(load_xpct), .load_mask(load_mask), .start(start),
      .pi(pi), .po(po), .busy(busy), .done(done), .pat_fail(pat_fail), .pat_idx(pat_idx),
      .fail_count(fail_count), .first_fail_valid(first_fail_valid),
      .first_fail_idx(first_fail_idx), .pat_count(pat_count)
   );

   function automatic logic [NO-1:0] model(input logic [NI-1:0] v);
      case (v)
         5'b11101: return 2'b10;
         5'b01101: return 2'b00;
         5'b01111: return 2'b01;
         5'b01000: return 2'b00;
         default:  return v[1:0] ^ v[3:2];
      endcase
   endfunction

   assign po = (inj_en && pat_idx == inj_idx) ? 2'b11 : model(pi);

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_entry(input string tag, input logic [NI-1:0] p,
                             input logic [NO-1:0] x, input logic [NO-1:0] m);
      bit exp_rdy;
      load_valid = 1'b1; load_pi = p; load_xpct = x; load_mask = m;
      #1;
      exp_rdy = (st_pi.size() < DEPTH);
      check_eq({tag, " load_ready"}, load_ready, exp_rdy);
      if (exp_rdy) begin
         st_pi.push_back(p); st_x.push_back(x); st_m.push_back(m);
      end
      @(posedge clk); #1;
      load_valid = 1'b0;
   endtask

   task automatic drop_store();
      st_pi.delete(); st_x.delete(); st_m.delete();
   endtask

   task automatic run_patterns(input string tag, input bit poke);
      int            n, exp_fc, exp_ffi, pulses;
      bit            exp_ffv, f;
      logic [NO-1:0] obs;
      logic [NI-1:0] cur_pi;
      n = st_pi.size(); exp_fc = 0; exp_ffi = 0; exp_ffv = 0; pulses = 0; cur_pi = '0;
      for (int k = 0; k < n; k++) begin
         obs = (inj_en && k == int'(inj_idx)) ? 2'b11 : model(st_pi[k]);
         f = |((obs ^ st_x[k]) & st_m[k]);
         exp_pi_q.push_back(st_pi[k]);
         exp_fail_q.push_back(f);
         if (f) begin
            exp_fc++;
            if (!exp_ffv) begin exp_ffv = 1; exp_ffi = k; end
         end
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c <= n * (SET + 1); c++) begin
         if (c > 0) tick();
         if (poke && c == 2) begin start = 1'b1; clr = 1'b1; end
         if (poke && c == 3) begin start = 1'b0; clr = 1'b0; end
         if (pat_fail) pulses++;
         if (c % (SET + 1) == 0) begin
            if (c > 0) check_eq({tag, " pat_fail"}, pat_fail, exp_fail_q.pop_front());
            if (c < n * (SET + 1)) begin
               cur_pi = exp_pi_q.pop_front();
               check_eq({tag, " pi"}, pi, cur_pi);
               check_eq({tag, " pat_idx"}, pat_idx, c / (SET + 1));
               check_eq({tag, " done/busy running"}, {done, busy}, 2'b01);
            end else begin
               check_eq({tag, " done/busy end"}, {done, busy}, 2'b10);
            end
         end else begin
            check_eq({tag, " settle hold"}, {done, busy, pat_fail, pi}, {3'b010, cur_pi});
         end
      end
      check_eq({tag, " pulses"}, pulses, exp_fc);
      check_eq({tag, " fail_count"}, fail_count, exp_fc);
      check_eq({tag, " first_fail_valid"}, first_fail_valid, exp_ffv);
      check_eq({tag, " first_fail_idx"}, first_fail_idx, exp_ffi);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; start = 1'b0;
      load_valid = 1'b1; load_pi = 5'b10101; load_xpct = 2'b11; load_mask = 2'b11;
      tick(); tick();
      check_eq("reset outputs",
               {pi, busy, done, pat_fail, pat_idx, fail_count, first_fail_valid,
                first_fail_idx, pat_count, load_ready}, 32'd0);
      load_valid = 1'b0;
      rst = 1'b0;
      #1;
      check_eq("load_ready after reset", load_ready, 1'b1);
      tick();

      // Passing run on three reference entries
      load_entry("ref0", 5'b11101, 2'b10, 2'b11);
      load_entry("ref1", 5'b01101, 2'b00, 2'b11);
      load_entry("ref2", 5'b01111, 2'b01, 2'b11);
      check_eq("pat_count 3", pat_count, 3);
      run_patterns("pass", 1'b0);
      check_eq("pi held in done", pi, 5'b01111);

      // Miscompare on entry 1, with start/clr pokes mid-run that must be ignored
      inj_en = 1'b1; inj_idx = 4'd1;
      run_patterns("miss", 1'b1);
      inj_en = 1'b0;
      tick(); tick(); tick();
      check_eq("results hold", {done, fail_count, first_fail_valid, first_fail_idx},
               {1'b1, 5'd1, 1'b1, 4'd1});

      clr = 1'b1;
      #1;
      check_eq("load_ready low on clr", load_ready, 1'b0);
      tick();
      clr = 1'b0;
      check_eq("clr result", {pat_count, done, busy, fail_count, first_fail_valid, first_fail_idx, pi},
               32'd0);
      drop_store();

      // Mask behaviour
      load_entry("mask10", 5'b01000, 2'b01, 2'b10);
      run_patterns("mask_pass", 1'b0);
      check_eq("mask_pass count", fail_count, 0);
      clr = 1'b1; tick(); clr = 1'b0; drop_store();
      load_entry("mask11", 5'b01000, 2'b01, 2'b11);
      run_patterns("mask_fail", 1'b0);
      check_eq("mask_fail count", fail_count, 1);

      // start and clr together: clr wins
      start = 1'b1; clr = 1'b1;
      tick();
      start = 1'b0; clr = 1'b0;
      check_eq("clr beats start", {pat_count, done, busy}, 7'd0);
      drop_store();

      // Empty start
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("empty start", {done, busy, fail_count}, {1'b1, 1'b0, 5'd0});
      tick();
      check_eq("empty start busy", {done, busy}, 2'b10);

      // Full store: 17 offers, 16 accepted
      for (int i = 0; i < DEPTH + 1; i++)
         load_entry($sformatf("full%0d", i), NI'($urandom_range(0, 31)),
                    NO'($urandom_range(0, 3)), NO'($urandom_range(0, 3)));
      check_eq("pat_count full", pat_count, 16);
      run_patterns("full", 1'b0);

      // Reset mid-run
      start = 1'b1; tick(); start = 1'b0;
      for (int w = 0; w < 50 && pat_idx != 4'd2; w++) tick();
      check_eq("reach idx 2", pat_idx, 2);
      rst = 1'b1;
      tick();
      check_eq("mid-run reset outputs",
               {pi, busy, done, pat_fail, pat_idx, fail_count, first_fail_valid,
                first_fail_idx, pat_count, load_ready}, 32'd0);
      rst = 1'b0;
      #1;
      check_eq("load_ready after mid reset", load_ready, 1'b1);
      drop_store();
      tick(); tick(); tick();
      check_eq("no resume", {busy, done, pi}, 7'd0);
      start = 1'b1; tick(); start = 1'b0;
      check_eq("start after reset", {done, busy, pat_count}, {1'b1, 1'b0, 5'd0});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/pattern_player.md
PATTERN_PLAYER -- requirements
Module: pattern_player

Interface
REQ-001 Parameter NINPUTS, default 5, SHALL set the width of the vector driven to the DUT inputs.
REQ-002 Parameter NOUTPUTS, default 2, SHALL set the width of the vector sampled from the DUT outputs.
REQ-003 Parameter DEPTH, default 16, SHALL set the number of pattern entries stored.
REQ-004 Parameter SETTLE, default 4 (minimum 1), SHALL set the number of settle cycles per pattern before measurement.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- clr  in  1  empty the pattern store; accepted in IDLE or DONE only
- load_valid  in  1  pattern entry offered
- load_ready  out  1  entry accepted this cycle when load_valid is also high
- load_pi  in  NINPUTS  stimulus vector
- load_xpct  in  NOUTPUTS  expected response
- load_mask  in  NOUTPUTS  compare mask; 1 = compare this bit
- start  in  1  begin a run over all stored entries
- pi  out  NINPUTS  stimulus to the DUT; registered
- po  in  NOUTPUTS  DUT response
- busy  out  1  run in progress
- done  out  1  run complete; level
- pat_fail  out  1  one-cycle pulse when the current pattern miscompares
- pat_idx  out  clog2(DEPTH)  index of the pattern being applied
- fail_count  out  clog2(DEPTH+1)  number of miscomparing patterns
- first_fail_valid  out  1  at least one miscompare in the run
- first_fail_idx  out  clog2(DEPTH)  index of the first miscomparing pattern
- pat_count  out  clog2(DEPTH+1)  number of stored entries

Function
REQ-007 The FSM SHALL have the states IDLE, SETTLE, MEASURE and DONE.
REQ-008 load_ready SHALL equal (state is IDLE or DONE) AND pat_count < DEPTH AND NOT start AND NOT clr.
REQ-009 When an entry is accepted, it SHALL be written at index pat_count, and pat_count SHALL increment.
REQ-010 When the store is full, load_ready SHALL be low, and offered entries SHALL be neither written nor counted.
REQ-011 clr in IDLE or DONE SHALL set pat_count to 0 next cycle, drop done, and clear fail_count, first_fail_valid and first_fail_idx.
REQ-012 clr in SETTLE or MEASURE SHALL be ignored.
REQ-013 start in IDLE or DONE with pat_count > 0 SHALL enter SETTLE next cycle, with all of the following:
- pat_idx = 0
- pi = entry 0
- busy = 1
- done = 0
- fail results cleared
REQ-014 start with pat_count = 0 SHALL go directly to DONE next cycle, with done = 1 and fail_count = 0.
REQ-015 start asserted in SETTLE or MEASURE SHALL be ignored.
REQ-016 If start and clr are asserted together, clr SHALL take precedence and start SHALL be ignored.
REQ-017 SETTLE SHALL last exactly SETTLE cycles, with pi held constant, and then SHALL transition to MEASURE.
REQ-018 MEASURE SHALL last one cycle and SHALL sample po in that cycle.
REQ-019 A pattern SHALL miscompare when ((po XOR xpct) AND mask) is nonzero.
REQ-020 A pattern with mask = 0 SHALL always pass.
REQ-021 On a miscompare, all of the following SHALL happen in the cycle after MEASURE:
- pat_fail pulses high for one cycle
- fail_count increments
- if first_fail_valid is 0: first_fail_valid is set and first_fail_idx = pat_idx
REQ-022 After MEASURE with pat_idx < pat_count-1, the block SHALL increment pat_idx, load pi with the next entry, and re-enter SETTLE.
REQ-023 After MEASURE of the last entry, the block SHALL enter DONE with busy = 0 and done = 1.
REQ-024 A run SHALL last pat_count × (SETTLE+1) cycles from the first SETTLE cycle to the assertion of done.
REQ-025 pi SHALL be 0 in IDLE and SHALL hold the last applied pattern in DONE.
REQ-026 Results (fail_count, first_fail_valid, first_fail_idx) SHALL hold in DONE until the next start, clr or rst.
REQ-027 fail_count SHALL never exceed pat_count, so it cannot overflow.

Reset
REQ-028 rst SHALL take precedence over all other inputs, including mid-run.
REQ-029 rst SHALL force state IDLE, with every one of the following outputs at 0:
- pi
- busy
- done
- pat_fail
- pat_idx
- fail_count
- first_fail_valid
- first_fail_idx
- pat_count
- load_ready
REQ-030 In the cycle after rst, load_ready SHALL be 1.
REQ-031 Pattern memory contents SHALL be don't-care after reset, because pat_count = 0.

Verification
REQ-032 Passing run: load (pi 11101, xpct 10, mask 11), (01101, 00, 11), (01111, 01, 11); model returns the expected po; start -> done after 15 cycles, fail_count = 0, first_fail_valid = 0.
REQ-033 Miscompare: load the same three entries; force po = 11 while entry 1 is applied -> exactly one pat_fail pulse, fail_count = 1, first_fail_idx = 1.
REQ-034 Mask: entry (01000, 01, 10), po = 00 -> pass; same entry with mask 11 -> fail.
REQ-035 Full store: offer 17 entries with DEPTH = 16 -> 16 accepted, load_ready low on the 17th, pat_count = 16.
REQ-036 Empty start: start with pat_count = 0 -> done = 1 next cycle, busy never high.
REQ-037 Reset mid-run: assert rst while pat_idx = 2 -> next cycle all outputs 0, state IDLE; the run does not resume; a subsequent start with no loads -> immediate done.
